// File: rtl/hs_unit_reg_slice_ctrl_pkg.sv
// Shared definitions for the handshake register slice.
// The slice controller state names the occupancy of the two data registers.
package hs_pkg_unit;

  typedef enum logic [1:0] {
    EMPTY = 2'b00,
    BUSY  = 2'b01,
    FULL  = 2'b10
  } hs_slice_state_e;

  localparam logic [1:0] OCC_NONE = 2'd0;
  localparam logic [1:0] OCC_ONE  = 2'd1;
  localparam logic [1:0] OCC_TWO  = 2'd2;

endpackage

// File: rtl/hs_unit_reg_slice_ctrl_if.sv
// Valid/ready streaming channel carrying a payload of any packed type.
// The master drives valid and data, the slave drives ready.
interface hs_unit_reg_slice_ctrl_if #(
  parameter type DATA_TYPE = logic
);

  logic     valid;
  logic     ready;
  DATA_TYPE data;

  modport master (
    output valid,
    output data,
    input  ready
  );

  modport slave (
    input  valid,
    input  data,
    output ready
  );

endinterface

// File: rtl/hs_unit_reg_slice_ctrl_dff.sv
// Clock-enabled data register without reset, used for the slice payload.
// Leaving out the reset keeps wide payload registers cheap; validity is
// tracked separately by the slice controller.
module hs_unit_dff_noreset_ce #(
  parameter type DATA_TYPE = logic
) (
  input  logic     clk,
  input  logic     ce,
  input  DATA_TYPE d,
  output DATA_TYPE q
);

  // Capture the input only when enabled; otherwise hold.
  always_ff @(posedge clk) begin
    if (ce) begin
      q <= d;
    end
  end

endmodule

// File: rtl/hs_unit_reg_slice_ctrl.sv
// Full-throughput valid/ready register slice (skid buffer).
// A three-state controller sequences a main and a skid data register so the
// upstream ready never depends combinationally on the downstream ready, while
// still sustaining one beat per cycle. The main register drives m.data.
module hs_unit_reg_slice_ctrl
  import hs_pkg_unit::*;
#(
  parameter type DATA_TYPE = logic
) (
  input  logic                     clk,
  input  logic                     rst,
  hs_unit_reg_slice_ctrl_if.slave  s,
  hs_unit_reg_slice_ctrl_if.master m,
  output logic [1:0]               occ
);

  hs_slice_state_e state_q;
  hs_slice_state_e state_d;

  logic       ce_main;
  logic       ce_skid;
  logic       sel_skid;
  logic       valid_st;
  logic       ready_st;
  logic [1:0] occ_st;

  DATA_TYPE main_d;
  DATA_TYPE main_q;
  DATA_TYPE skid_q;

  // State register; reset discards any in-flight beats by returning to EMPTY.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= EMPTY;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state, register enables and state-decoded flags; ready and valid
  // come from the registered state only, never from the handshake inputs.
  always_comb begin
    state_d  = state_q;
    ce_main  = 1'b0;
    ce_skid  = 1'b0;
    sel_skid = 1'b0;
    valid_st = 1'b0;
    ready_st = 1'b0;
    occ_st   = OCC_NONE;
    case (state_q)
      EMPTY: begin
        ready_st = 1'b1;
        if (s.valid) begin
          ce_main = 1'b1;
          state_d = BUSY;
        end
      end
      BUSY: begin
        valid_st = 1'b1;
        ready_st = 1'b1;
        occ_st   = OCC_ONE;
        if (s.valid && m.ready) begin
          ce_main = 1'b1;
        end else if (s.valid) begin
          ce_skid = 1'b1;
          state_d = FULL;
        end else if (m.ready) begin
          state_d = EMPTY;
        end
      end
      FULL: begin
        valid_st = 1'b1;
        occ_st   = OCC_TWO;
        sel_skid = 1'b1;
        if (m.ready) begin
          ce_main = 1'b1;
          state_d = BUSY;
        end
      end
      default: begin
        state_d = EMPTY;
      end
    endcase
  end

  // The main register refills from the skid register when draining FULL.
  always_comb begin
    main_d = sel_skid ? skid_q : s.data;
  end

  hs_unit_dff_noreset_ce #(.DATA_TYPE(DATA_TYPE)) u_main (
    .clk (clk),
    .ce  (ce_main),
    .d   (main_d),
    .q   (main_q)
  );

  hs_unit_dff_noreset_ce #(.DATA_TYPE(DATA_TYPE)) u_skid (
    .clk (clk),
    .ce  (ce_skid),
    .d   (s.data),
    .q   (skid_q)
  );

  // While reset is held the slice looks idle and refuses input.
  assign s.ready = ready_st & ~rst;
  assign m.valid = valid_st & ~rst;
  assign m.data  = main_q;
  assign occ     = rst ? OCC_NONE : occ_st;

endmodule

// File: tb/tb_hs_unit_reg_slice_ctrl.sv
// Self-checking bench for the handshake register slice, using a 16-bit struct
// payload. The reference model is a two-entry FIFO queue: a beat enters when
// valid is high and fewer than two beats are held, and leaves when the queue
// is non-empty and the consumer is ready.
module tb_hs_unit_reg_slice_ctrl;

  typedef struct packed {
    logic [7:0] hi;
    logic [7:0] lo;
  } beat_t;

  logic       clk = 1'b0;
  logic       rst;
  logic [1:0] occ;

  int checkCount = 0;
  int errorCount = 0;

  beat_t modelQ[$];

  hs_unit_reg_slice_ctrl_if #(.DATA_TYPE(beat_t)) up ();
  hs_unit_reg_slice_ctrl_if #(.DATA_TYPE(beat_t)) dn ();

  hs_unit_reg_slice_ctrl #(.DATA_TYPE(beat_t)) dut (
    .clk (clk),
    .rst (rst),
    .s   (up),
    .m   (dn),
    .occ (occ)
  );

  always #5 clk = ~clk;

  // Single comparison point: counts every check and reports mismatches.
  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checkCount++;
    if (observed !== expected) begin
      errorCount++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", tag, observed,
               expected, $time);
    end
  endtask

  function automatic beat_t mk(input logic [7:0] v);
    beat_t b;
    b.hi = 8'h00;
    b.lo = v;
    return b;
  endfunction

  // Drive one cycle of inputs, check ready before the edge (it must not follow
  // m_ready), advance the model across the edge, then check all outputs.
  task automatic applyStimulus(input logic r, input logic sv, input logic mr,
                               input beat_t d);
    logic fin;
    logic fout;
    rst      = r;
    up.valid = sv;
    up.data  = d;
    dn.ready = mr;
    #1;
    checkOutput("s_ready_pre", 32'(up.ready), 32'(!r && modelQ.size() < 2));
    @(posedge clk);
    if (r) begin
      modelQ.delete();
    end else begin
      fin  = sv && (modelQ.size() < 2);
      fout = mr && (modelQ.size() > 0);
      if (fout) void'(modelQ.pop_front());
      if (fin) modelQ.push_back(d);
    end
    #1;
    checkOutput("occ", 32'(occ), r ? 32'd0 : 32'(modelQ.size()));
    checkOutput("m_valid", 32'(dn.valid), 32'(!r && modelQ.size() > 0));
    checkOutput("s_ready", 32'(up.ready), 32'(!r && modelQ.size() < 2));
    if (!r && modelQ.size() > 0) begin
      checkOutput("m_data", 32'(dn.data), 32'(modelQ[0]));
    end
  endtask

  initial begin
    int seq;

    // Reset held with traffic offered; the slice must stay idle.
    for (int i = 0; i < 3; i++) applyStimulus(1'b1, 1'b1, 1'b0, mk(8'hAA));
    applyStimulus(1'b0, 1'b0, 1'b0, mk(8'h00));

    // Back-to-back streaming with the consumer always ready.
    for (int i = 1; i <= 16; i++) applyStimulus(1'b0, 1'b1, 1'b1, mk(8'(i)));
    applyStimulus(1'b0, 1'b0, 1'b1, mk(8'h00));

    // Backpressure fill to two beats, then drain.
    applyStimulus(1'b0, 1'b1, 1'b0, mk(8'h11));
    applyStimulus(1'b0, 1'b1, 1'b0, mk(8'h22));
    applyStimulus(1'b0, 1'b0, 1'b0, mk(8'h00));
    applyStimulus(1'b0, 1'b0, 1'b0, mk(8'h00));
    applyStimulus(1'b0, 1'b0, 1'b1, mk(8'h00));
    applyStimulus(1'b0, 1'b0, 1'b1, mk(8'h00));

    // Full with upstream pending: one ready pulse frees a slot for 8'h33.
    applyStimulus(1'b0, 1'b1, 1'b0, mk(8'h21));
    applyStimulus(1'b0, 1'b1, 1'b0, mk(8'h22));
    applyStimulus(1'b0, 1'b1, 1'b0, mk(8'h33));
    applyStimulus(1'b0, 1'b1, 1'b0, mk(8'h33));
    applyStimulus(1'b0, 1'b1, 1'b1, mk(8'h33));
    applyStimulus(1'b0, 1'b1, 1'b0, mk(8'h33));
    applyStimulus(1'b0, 1'b0, 1'b0, mk(8'h00));
    for (int i = 0; i < 3; i++) applyStimulus(1'b0, 1'b0, 1'b1, mk(8'h00));

    // Reset while full; old beats must not resurface.
    applyStimulus(1'b0, 1'b1, 1'b0, mk(8'h55));
    applyStimulus(1'b0, 1'b1, 1'b0, mk(8'h66));
    applyStimulus(1'b1, 1'b0, 1'b0, mk(8'h00));
    for (int i = 0; i < 3; i++) applyStimulus(1'b0, 1'b0, 1'b1, mk(8'h00));
    applyStimulus(1'b0, 1'b1, 1'b0, mk(8'h44));
    applyStimulus(1'b0, 1'b0, 1'b1, mk(8'h00));
    applyStimulus(1'b0, 1'b0, 1'b1, mk(8'h00));

    // Random valid/ready with a running sequence number as payload.
    seq = 1;
    for (int i = 0; i < 10000; i++) begin
      logic sv;
      logic mr;
      sv = ($urandom % 4) != 0;
      mr = ($urandom % 3) != 0;
      applyStimulus(1'b0, sv, mr, beat_t'(16'(seq)));
      if (sv && (modelQ.size() > 0) && (modelQ[modelQ.size() - 1] == beat_t'(16'(seq)))) begin
        seq++;
      end
    end
    for (int i = 0; i < 3; i++) applyStimulus(1'b0, 1'b0, 1'b1, mk(8'h00));

    $display("Result: errors=%0d of %0d checks", errorCount, checkCount);
    $finish;
  end

endmodule
